pio_cfg_loader: RTL
===================

# pio_cfg_loader

Configuration sequencer in front of the `pio` block's action port. On a `start` pulse it streams a program from an external instruction memory into the PIO (INSTR actions), writes PEND/DIV/GRPS for each selected state machine, then optionally issues one EN action. While idle it forwards a host action port to the PIO, so one port is shared between software-style host writes and automated bring-up.

## Interface
- PROG_DEPTH, 32, instruction slots; `prog_addr` and `index` are clog2(PROG_DEPTH) bits wide.
- NUM_SM, 4, state machines; `mindex` is clog2(NUM_SM) bits wide.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled only when `busy`=0.
- plen  in  6  program length, 0..PROG_DEPTH.
- sm_mask  in  NUM_SM  machines to configure.
- enable  in  1  issue EN after configuration.
- div  in  24  DIV payload.
- pin_grps  in  32  GRPS payload.
- exec_ctrl  in  32  PEND payload.
- prog_addr  out  5  instruction memory address.
- prog_data  in  16  instruction word, valid the cycle after `prog_addr`.
- host_action  in  6  host action code.
- host_index  in  5  host index.
- host_mindex  in  2  host machine index.
- host_din  in  32  host data.
- host_ready  out  1  host action accepted this cycle.
- action  out  6  to pio.action.
- index  out  5  to pio.index.
- mindex  out  2  to pio.mindex.
- din  out  32  to pio.din.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at completion.
- err  out  1  one-cycle pulse: start rejected.

## Operation
- Action codes: NONE=0, INSTR=1, PEND=2, GRPS=5, EN=6, DIV=7.
- All outputs are registered. Each action is held for exactly one cycle, and the PIO samples it at that cycle's closing edge.
- States: IDLE, FETCH, INSTR, CFG, EN, DONE.
- IDLE, start=1 and plen<=PROG_DEPTH:
  - Latch plen, sm_mask, enable, div, pin_grps and exec_ctrl.
  - Go to FETCH with addr=0. Go to INSTR after the fetch cycle when plen>0; when plen=0, go to CFG after the same delay.
- IDLE, start=1 and plen>PROG_DEPTH: `err` pulses the next cycle; the block stays IDLE and issues no actions.
- INSTR: one action per cycle, `action`=INSTR, `index`=i, `din`={16'b0, mem[i]} for i=0..plen-1. Instructions are back-to-back with `prog_addr` running one cycle ahead. `prog_addr` holds its last value after the final fetch.
- CFG: for each set bit m of the latched sm_mask, in ascending m order, issue three consecutive actions, all with `mindex`=m:
  1. PEND, `din`=exec_ctrl.
  2. DIV, `din`={8'b0, div}.
  3. GRPS, `din`=pin_grps.
  - `index`=0 for all three.
- EN: only when enable=1 and sm_mask!=0. One action EN, `din`=sm_mask zero-extended, `mindex`=0.
- DONE: `action`=NONE, `done`=1, `busy`=0 in the same cycle; next state IDLE.
- Host path:
  - `host_ready`=!busy (registered copy of the next busy state).
  - In IDLE, `host_*` is registered onto `action/index/mindex/din` with one-cycle latency.
  - While busy, host inputs are ignored and `host_ready`=0.
  - If start and a nonzero host_action arrive in the same IDLE cycle, the host action is forwarded in cycle 1; sequence actions only begin at cycle 3, so there is no collision.
- start while busy is ignored, with no err.
- Latched parameters are immune to input changes mid-sequence.

## Timing
- Reset values:
  - `action`, `index`, `mindex`, `din`, `prog_addr`, `busy`, `done`, `err`: 0.
  - `host_ready`: 1 from the first cycle after reset deasserts.
- Cycle 0 = start sampled.
  - Cycle 1: busy=1, prog_addr=0, action=NONE (or the forwarded host action).
  - Cycle 2: prog_data=mem[0], prog_addr=1.
  - First INSTR in cycle 3. Last INSTR in cycle 2+plen.
- With k = popcount(sm_mask):
  - CFG occupies cycles 3+plen .. 2+plen+3k.
  - EN at 3+plen+3k.
  - done at 4+plen+3k, or 3+plen+3k when there is no EN.
- plen=0, sm_mask=0, enable=1: no EN; done at cycle 3.
- Reset during any state: abandon the sequence next edge, apply all reset values, no done pulse, no partial action held.
- Back-to-back: start asserted in the done cycle is accepted, since busy=0 that cycle, and restarts at cycle 0.

## Test plan
- plen=2, mem={E081,0000}, sm_mask=0001, enable=1, div=000280, pin_grps=04000000, exec_ctrl=00001000 -> expect:
  - INSTR i0/E081 at cycle 3 and i1/0000 at cycle 4.
  - PEND/DIV/GRPS on mindex 0 at cycles 5-7.
  - EN din=1 at cycle 8.
  - done at cycle 9.
- sm_mask=1010, plen=1, enable=0 -> 1 INSTR, then PEND/DIV/GRPS with mindex=1, then with mindex=3; no EN; done at cycle 10.
- plen=33 -> err pulse at cycle 1; busy stays 0; action stays NONE.
- Idle host_action=IMM(9), host_din=E001 -> action=9, din=E001 one cycle later. Host write while busy -> host_ready=0 and the write is not forwarded.
- Reset asserted at cycle 4 of a plen=8 load -> action=0, busy=0, no done. A new start then completes normally with the full sequence.
- start held high continuously -> a new sequence starts in each done cycle; consecutive sequences never overlap.

Source files
------------

// File: rtl/pio_cfg_loader_if.sv
// Shared action port: host-side requests into the loader and the loader's action bus to the pio.
// The loader takes the slave modport. The environment (host plus pio) takes the master modport.
interface pio_cfg_loader_if #(
   parameter int unsigned IDX_W  = 5,
   parameter int unsigned MIDX_W = 2
);
   logic [5:0]        host_action;
   logic [IDX_W-1:0]  host_index;
   logic [MIDX_W-1:0] host_mindex;
   logic [31:0]       host_din;
   logic              host_ready;

   logic [5:0]        action;
   logic [IDX_W-1:0]  index;
   logic [MIDX_W-1:0] mindex;
   logic [31:0]       din;

   modport master (
      output host_action, host_index, host_mindex, host_din,
      input  host_ready,
      input  action, index, mindex, din
   );

   modport slave (
      input  host_action, host_index, host_mindex, host_din,
      output host_ready,
      output action, index, mindex, din
   );
endinterface

// File: rtl/pio_cfg_loader.sv
// Bring-up sequencer for the pio action port: streams a program, then PEND/DIV/GRPS per machine
// and an optional EN. While idle it forwards host actions onto the same port.
module pio_cfg_loader #(
   parameter int unsigned  PROG_DEPTH = 32,
   parameter int unsigned  NUM_SM     = 4,
   localparam int unsigned AW         = $clog2(PROG_DEPTH),
   localparam int unsigned MW         = $clog2(NUM_SM)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AW:0]       plen,
   input  logic [NUM_SM-1:0] sm_mask,
   input  logic              enable,
   input  logic [23:0]       div,
   input  logic [31:0]       pin_grps,
   input  logic [31:0]       exec_ctrl,
   output logic [AW-1:0]     prog_addr,
   input  logic [15:0]       prog_data,
   pio_cfg_loader_if.slave   bus,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [5:0] ACT_NONE  = 6'd0;
   localparam logic [5:0] ACT_INSTR = 6'd1;
   localparam logic [5:0] ACT_PEND  = 6'd2;
   localparam logic [5:0] ACT_GRPS  = 6'd5;
   localparam logic [5:0] ACT_EN    = 6'd6;
   localparam logic [5:0] ACT_DIV   = 6'd7;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_INSTR = 3'd2;
   localparam logic [2:0] ST_CFG   = 3'd3;
   localparam logic [2:0] ST_EN    = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [AW:0] PLEN_MAX = (AW + 1)'(PROG_DEPTH);
   localparam logic [AW:0] ONE      = (AW + 1)'(1);
   localparam logic [AW:0] TWO      = (AW + 1)'(2);

   logic [2:0]        state_q, state_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [1:0]        step_q, step_d;
   logic [NUM_SM-1:0] rem_q, rem_d;
   logic [AW:0]       plen_q, plen_d;
   logic [NUM_SM-1:0] mask_q, mask_d;
   logic              en_q, en_d;
   logic [23:0]       div_q, div_d;
   logic [31:0]       grps_q, grps_d;
   logic [31:0]       ectl_q, ectl_d;
   logic [AW-1:0]     prog_addr_q, prog_addr_d;
   logic [5:0]        action_q, action_d;
   logic [AW-1:0]     index_q, index_d;
   logic [MW-1:0]     mindex_q, mindex_d;
   logic [31:0]       din_q, din_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              host_ready_q;

   logic [MW-1:0]     cur_m;
   logic [NUM_SM-1:0] rem_nxt;
   logic [AW:0]       cnt_inc;
   logic [AW:0]       fetch_nxt;

   assign cnt_inc   = cnt_q + ONE;
   assign fetch_nxt = cnt_q + TWO;

   // Lowest machine still pending in the CFG walk, and the mask once it is retired.
   always_comb begin
      cur_m = '0;
      for (int i = NUM_SM - 1; i >= 0; i--) begin
         if (rem_q[i]) cur_m = MW'(i);
      end
      rem_nxt        = rem_q;
      rem_nxt[cur_m] = 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      rem_d       = rem_q;
      plen_d      = plen_q;
      mask_d      = mask_q;
      en_d        = en_q;
      div_d       = div_q;
      grps_d      = grps_q;
      ectl_d      = ectl_q;
      prog_addr_d = prog_addr_q;
      busy_d      = busy_q;
      action_d    = ACT_NONE;
      index_d     = '0;
      mindex_d    = '0;
      din_d       = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            action_d = bus.host_action;
            index_d  = bus.host_index;
            mindex_d = bus.host_mindex;
            din_d    = bus.host_din;
            if (start) begin
               if (plen <= PLEN_MAX) begin
                  plen_d      = plen;
                  mask_d      = sm_mask;
                  rem_d       = sm_mask;
                  en_d        = enable;
                  div_d       = div;
                  grps_d      = pin_grps;
                  ectl_d      = exec_ctrl;
                  cnt_d       = '0;
                  step_d      = '0;
                  prog_addr_d = '0;
                  busy_d      = 1'b1;
                  state_d     = ST_FETCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         // mem[0] is requested this cycle; prefetch mem[1] so INSTR runs back-to-back.
         ST_FETCH: begin
            if (plen_q > ONE) prog_addr_d = AW'(1);
            if (plen_q != '0)      state_d = ST_INSTR;
            else if (mask_q != '0) state_d = ST_CFG;
            else                   state_d = ST_DONE;
         end

         ST_INSTR: begin
            action_d = ACT_INSTR;
            index_d  = cnt_q[AW-1:0];
            din_d    = {16'b0, prog_data};
            cnt_d    = cnt_inc;
            if (fetch_nxt < plen_q) prog_addr_d = fetch_nxt[AW-1:0];
            if (cnt_inc == plen_q) state_d = (mask_q != '0) ? ST_CFG : ST_DONE;
         end

         ST_CFG: begin
            mindex_d = cur_m;
            step_d   = step_q + 2'd1;
            unique case (step_q)
               2'd0: begin
                  action_d = ACT_PEND;
                  din_d    = ectl_q;
               end
               2'd1: begin
                  action_d = ACT_DIV;
                  din_d    = {8'b0, div_q};
               end
               default: begin
                  action_d = ACT_GRPS;
                  din_d    = grps_q;
                  step_d   = '0;
                  rem_d    = rem_nxt;
                  if (rem_nxt == '0) state_d = en_q ? ST_EN : ST_DONE;
               end
            endcase
         end

         ST_EN: begin
            action_d = ACT_EN;
            din_d    = 32'(mask_q);
            state_d  = ST_DONE;
         end

         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         step_q       <= '0;
         rem_q        <= '0;
         plen_q       <= '0;
         mask_q       <= '0;
         en_q         <= 1'b0;
         div_q        <= '0;
         grps_q       <= '0;
         ectl_q       <= '0;
         prog_addr_q  <= '0;
         action_q     <= ACT_NONE;
         index_q      <= '0;
         mindex_q     <= '0;
         din_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         host_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         step_q       <= step_d;
         rem_q        <= rem_d;
         plen_q       <= plen_d;
         mask_q       <= mask_d;
         en_q         <= en_d;
         div_q        <= div_d;
         grps_q       <= grps_d;
         ectl_q       <= ectl_d;
         prog_addr_q  <= prog_addr_d;
         action_q     <= action_d;
         index_q      <= index_d;
         mindex_q     <= mindex_d;
         din_q        <= din_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         host_ready_q <= !busy_d;
      end
   end

   assign prog_addr      = prog_addr_q;
   assign bus.action     = action_q;
   assign bus.index      = index_q;
   assign bus.mindex     = mindex_q;
   assign bus.din        = din_q;
   assign bus.host_ready = host_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;

endmodule
